// File: rtl/arith_unit_sequencer_if.sv
// Bundle of command, unit-drive, response and statistics signals for arith_unit_sequencer.
// master is the requester/unit side, slave is the sequencer itself.
interface arith_unit_sequencer_if #(
  parameter int BITS  = 32,
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [BITS-1:0]  cmd_arg_a;
  logic [BITS-1:0]  cmd_arg_b;
  logic [1:0]       cmd_op;
  logic [BITS-1:0]  alu_arg_a;
  logic [BITS-1:0]  alu_arg_b;
  logic [1:0]       alu_op;
  logic [BITS-1:0]  alu_result;
  logic [3:0]       alu_status;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [BITS-1:0]  rsp_result;
  logic [3:0]       rsp_status;
  logic [1:0]       rsp_op;
  logic             busy;
  logic             cnt_clear;
  logic [CNT_W-1:0] cnt_done;
  logic [CNT_W-1:0] cnt_err;

  modport master (
    output cmd_valid, cmd_arg_a, cmd_arg_b, cmd_op, alu_result, alu_status,
           rsp_ready, cnt_clear,
    input  cmd_ready, alu_arg_a, alu_arg_b, alu_op, rsp_valid, rsp_result,
           rsp_status, rsp_op, busy, cnt_done, cnt_err
  );

  modport slave (
    input  cmd_valid, cmd_arg_a, cmd_arg_b, cmd_op, alu_result, alu_status,
           rsp_ready, cnt_clear,
    output cmd_ready, alu_arg_a, alu_arg_b, alu_op, rsp_valid, rsp_result,
           rsp_status, rsp_op, busy, cnt_done, cnt_err
  );
endinterface

// File: rtl/arith_unit_sequencer.sv
// Single-outstanding driver for the registered arithmetic unit: latch a command,
// wait the unit's fixed latency, capture result/status and hand them back.
module arith_unit_sequencer #(
  parameter int BITS    = 32,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  arith_unit_sequencer_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] LAT    = 4'(LATENCY);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == {CNT_W{1'b1}}) return c;
    else                    return c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic [1:0]       state_r;
  logic [1:0]       state_nx_s;
  logic [3:0]       lat_cnt_r;
  logic             cmd_ready_r;
  logic             busy_r;
  logic [BITS-1:0]  alu_arg_a_r;
  logic [BITS-1:0]  alu_arg_b_r;
  logic [1:0]       alu_op_r;
  logic             rsp_valid_r;
  logic [BITS-1:0]  rsp_result_r;
  logic [3:0]       rsp_status_r;
  logic [1:0]       rsp_op_r;
  logic [CNT_W-1:0] cnt_done_r;
  logic [CNT_W-1:0] cnt_err_r;
  logic             accept_s;
  logic             capture_s;
  logic             rsp_hs_s;

  // next-state decode and per-cycle event strobes
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    capture_s  = 1'b0;
    rsp_hs_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.cmd_valid && cmd_ready_r) begin
          accept_s   = 1'b1;
          state_nx_s = S_WAIT;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (lat_cnt_r == 4'd0) begin
          capture_s  = 1'b1;
          state_nx_s = S_RESP;
        end else begin
          state_nx_s = S_WAIT;
        end
      end
      S_RESP: begin
        if (rsp_valid_r && bus.rsp_ready) begin
          rsp_hs_s   = 1'b1;
          state_nx_s = S_IDLE;
        end else begin
          state_nx_s = S_RESP;
        end
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // FSM state plus ready/busy registered from the next state, so both are 0 in reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      cmd_ready_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      cmd_ready_r <= (state_nx_s == S_IDLE);
      busy_r      <= (state_nx_s != S_IDLE);
    end
  end

  // command latch and latency countdown
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_arg_a_r <= {BITS{1'b0}};
      alu_arg_b_r <= {BITS{1'b0}};
      alu_op_r    <= 2'd0;
      rsp_op_r    <= 2'd0;
      lat_cnt_r   <= 4'd0;
    end else if (accept_s) begin
      alu_arg_a_r <= bus.cmd_arg_a;
      alu_arg_b_r <= bus.cmd_arg_b;
      alu_op_r    <= bus.cmd_op;
      rsp_op_r    <= bus.cmd_op;
      lat_cnt_r   <= LAT;
    end else if (state_r == S_WAIT && lat_cnt_r != 4'd0) begin
      lat_cnt_r   <= lat_cnt_r - 4'd1;
    end
  end

  // response capture; result/status persist after the handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_r  <= 1'b0;
      rsp_result_r <= {BITS{1'b0}};
      rsp_status_r <= 4'd0;
    end else if (capture_s) begin
      rsp_valid_r  <= 1'b1;
      rsp_result_r <= bus.alu_result;
      rsp_status_r <= bus.alu_status;
    end else if (rsp_hs_s) begin
      rsp_valid_r  <= 1'b0;
    end
  end

  // saturating statistics; clear wins over a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_done_r <= {CNT_W{1'b0}};
      cnt_err_r  <= {CNT_W{1'b0}};
    end else if (bus.cnt_clear) begin
      cnt_done_r <= {CNT_W{1'b0}};
      cnt_err_r  <= {CNT_W{1'b0}};
    end else if (rsp_hs_s) begin
      cnt_done_r <= sat_inc(cnt_done_r);
      if (rsp_status_r[3]) cnt_err_r <= sat_inc(cnt_err_r);
    end
  end

  assign bus.cmd_ready  = cmd_ready_r;
  assign bus.busy       = busy_r;
  assign bus.alu_arg_a  = alu_arg_a_r;
  assign bus.alu_arg_b  = alu_arg_b_r;
  assign bus.alu_op     = alu_op_r;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_result = rsp_result_r;
  assign bus.rsp_status = rsp_status_r;
  assign bus.rsp_op     = rsp_op_r;
  assign bus.cnt_done   = cnt_done_r;
  assign bus.cnt_err    = cnt_err_r;

endmodule

// File: tb/tb_arith_unit_sequencer.sv
// Directed bench: instance a (LATENCY=1, CNT_W=16) and instance b (LATENCY=3, CNT_W=2),
// each driving a one-cycle registered model of the arithmetic unit.
module tb_arith_unit_sequencer;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  arith_unit_sequencer_if #(.BITS(32), .CNT_W(16)) bus_a ();
  arith_unit_sequencer_if #(.BITS(32), .CNT_W(2))  bus_b ();

  arith_unit_sequencer #(.BITS(32), .LATENCY(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst_a), .bus(bus_a));
  arith_unit_sequencer #(.BITS(32), .LATENCY(3), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst_b), .bus(bus_b));

  int n_vec  = 0;
  int n_miss = 0;
  logic [31:0] perturb_a = 32'd0;
  logic [3:0]  stat_a = 4'd0;
  logic [3:0]  stat_b = 4'd0;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] op);
    case (op)
      2'b00:   return a;
      2'b01:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      2'b10:   return a | (32'd1 << b[4:0]);
      default: return a << b[4:0];
    endcase
  endfunction

  always_ff @(posedge clk) begin
    bus_a.alu_result <= alu_f(bus_a.alu_arg_a, bus_a.alu_arg_b, bus_a.alu_op) ^ perturb_a;
    bus_a.alu_status <= stat_a;
    bus_b.alu_result <= alu_f(bus_b.alu_arg_a, bus_b.alu_arg_b, bus_b.alu_op);
    bus_b.alu_status <= stat_b;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // present a command and return at the negedge just after the accepting edge
  task automatic accept_a(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                          input logic [3:0] st);
    int n = 0;
    @(negedge clk);
    bus_a.cmd_arg_a = a; bus_a.cmd_arg_b = b; bus_a.cmd_op = op; stat_a = st;
    bus_a.cmd_valid = 1'b1;
    while (!bus_a.cmd_ready && n < 20) begin @(negedge clk); n++; end
    check("a_accept_timeout", 32'(n < 20), 32'd1);
    @(negedge clk);
    bus_a.cmd_valid = 1'b0;
  endtask

  task automatic accept_b(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                          input logic [3:0] st);
    int n = 0;
    @(negedge clk);
    bus_b.cmd_arg_a = a; bus_b.cmd_arg_b = b; bus_b.cmd_op = op; stat_b = st;
    bus_b.cmd_valid = 1'b1;
    while (!bus_b.cmd_ready && n < 20) begin @(negedge clk); n++; end
    check("b_accept_timeout", 32'(n < 20), 32'd1);
    @(negedge clk);
    bus_b.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp_a();
    int n = 0;
    while (!bus_a.rsp_valid && n < 20) begin @(negedge clk); n++; end
    check("a_rsp_timeout", 32'(n < 20), 32'd1);
  endtask

  task automatic wait_rsp_b();
    int n = 0;
    while (!bus_b.rsp_valid && n < 20) begin @(negedge clk); n++; end
    check("b_rsp_timeout", 32'(n < 20), 32'd1);
  endtask

  // full transaction on instance a, optionally clearing counters on the handshake cycle
  task automatic do_cmd_a(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                          input logic [3:0] st, input logic [31:0] exp, input logic clr);
    accept_a(a, b, op, st);
    wait_rsp_a();
    check("a_result", bus_a.rsp_result, exp);
    check("a_status", 32'(bus_a.rsp_status), 32'(st));
    check("a_op", 32'(bus_a.rsp_op), 32'(op));
    bus_a.rsp_ready = 1'b1; bus_a.cnt_clear = clr;
    @(negedge clk);
    bus_a.rsp_ready = 1'b0; bus_a.cnt_clear = 1'b0;
    check("a_rsp_drop", 32'(bus_a.rsp_valid), 32'd0);
  endtask

  initial begin
    logic seen;
    bus_a.cmd_valid = 1'b0; bus_a.cmd_arg_a = 32'd0; bus_a.cmd_arg_b = 32'd0;
    bus_a.cmd_op = 2'd0; bus_a.rsp_ready = 1'b0; bus_a.cnt_clear = 1'b0;
    bus_b.cmd_valid = 1'b0; bus_b.cmd_arg_a = 32'd0; bus_b.cmd_arg_b = 32'd0;
    bus_b.cmd_op = 2'd0; bus_b.rsp_ready = 1'b0; bus_b.cnt_clear = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(bus_a.cmd_ready), 32'd0);
    check("rst_busy", 32'(bus_a.busy), 32'd0);
    check("rst_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
    check("rst_alu_a", bus_a.alu_arg_a, 32'd0);
    check("rst_cnt_done", 32'(bus_a.cnt_done), 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;

    // basic shift, LATENCY=1: valid rises after the second edge past acceptance
    accept_a(32'h0000_000F, 32'h0000_0004, 2'b11, 4'b0000);
    check("basic_alu_a", bus_a.alu_arg_a, 32'h0000_000F);
    check("basic_alu_b", bus_a.alu_arg_b, 32'h0000_0004);
    check("basic_alu_op", 32'(bus_a.alu_op), 32'd3);
    check("basic_busy", 32'(bus_a.busy), 32'd1);
    check("basic_ready_lo", 32'(bus_a.cmd_ready), 32'd0);
    check("basic_valid_t0", 32'(bus_a.rsp_valid), 32'd0);
    @(negedge clk);
    check("basic_valid_t1", 32'(bus_a.rsp_valid), 32'd0);
    @(negedge clk);
    check("basic_valid_t2", 32'(bus_a.rsp_valid), 32'd1);
    check("basic_result", bus_a.rsp_result, 32'h0000_00F0);
    check("basic_op", 32'(bus_a.rsp_op), 32'd3);
    check("basic_busy_resp", 32'(bus_a.busy), 32'd1);
    bus_a.rsp_ready = 1'b1;
    @(negedge clk);
    bus_a.rsp_ready = 1'b0;
    check("basic_idle_busy", 32'(bus_a.busy), 32'd0);
    check("basic_idle_ready", 32'(bus_a.cmd_ready), 32'd1);
    check("basic_cnt_done", 32'(bus_a.cnt_done), 32'd1);
    check("basic_result_kept", bus_a.rsp_result, 32'h0000_00F0);

    // backpressure: response frozen while the unit output wanders, next command waits
    accept_a(32'hFFFF_FFFB, 32'h0000_0002, 2'b01, 4'b0000);
    wait_rsp_a();
    check("bp_result", bus_a.rsp_result, 32'h0000_0001);
    bus_a.cmd_arg_a = 32'h0000_0100; bus_a.cmd_arg_b = 32'h0000_0003;
    bus_a.cmd_op = 2'b10; bus_a.cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      perturb_a = 32'(i + 1) << 8;
      @(negedge clk);
      check("bp_hold_result", bus_a.rsp_result, 32'h0000_0001);
      check("bp_hold_valid", 32'(bus_a.rsp_valid), 32'd1);
      check("bp_hold_op", 32'(bus_a.rsp_op), 32'd1);
      check("bp_ready_lo", 32'(bus_a.cmd_ready), 32'd0);
    end
    perturb_a = 32'd0;
    bus_a.rsp_ready = 1'b1;
    @(negedge clk);
    bus_a.rsp_ready = 1'b0;
    check("bp_hs_valid", 32'(bus_a.rsp_valid), 32'd0);
    check("bp_hs_ready", 32'(bus_a.cmd_ready), 32'd1);
    check("bp_not_yet", bus_a.alu_arg_a, 32'hFFFF_FFFB);
    @(negedge clk);
    bus_a.cmd_valid = 1'b0;
    check("bp_accept2", bus_a.alu_arg_a, 32'h0000_0100);
    check("bp_busy2", 32'(bus_a.busy), 32'd1);
    wait_rsp_a();
    check("bp_result2", bus_a.rsp_result, 32'h0000_0108);
    bus_a.rsp_ready = 1'b1;
    @(negedge clk);
    bus_a.rsp_ready = 1'b0;
    check("bp_cnt_done", 32'(bus_a.cnt_done), 32'd3);
    check("bp_cnt_err", 32'(bus_a.cnt_err), 32'd0);

    // error counting, then clear colliding with a handshake
    bus_a.cnt_clear = 1'b1;
    @(negedge clk);
    bus_a.cnt_clear = 1'b0;
    check("clr_done", 32'(bus_a.cnt_done), 32'd0);
    do_cmd_a(32'h0000_1234, 32'd0, 2'b00, 4'b0000, 32'h0000_1234, 1'b0);
    do_cmd_a(32'h0000_0007, 32'hFFFF_FFFF, 2'b01, 4'b1000, 32'h0000_0000, 1'b0);
    do_cmd_a(32'h0000_0001, 32'd31, 2'b11, 4'b0100, 32'h8000_0000, 1'b0);
    check("err_cnt_done", 32'(bus_a.cnt_done), 32'd3);
    check("err_cnt_err", 32'(bus_a.cnt_err), 32'd1);
    do_cmd_a(32'h0000_0005, 32'd0, 2'b00, 4'b1000, 32'h0000_0005, 1'b1);
    check("clr_hs_done", 32'(bus_a.cnt_done), 32'd0);
    check("clr_hs_err", 32'(bus_a.cnt_err), 32'd0);

    // LATENCY=3: valid rises after the fourth edge past acceptance
    accept_b(32'h0000_000F, 32'h0000_0004, 2'b11, 4'b1000);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("lat3_early", 32'(bus_b.rsp_valid), 32'd0);
    end
    @(negedge clk);
    check("lat3_valid", 32'(bus_b.rsp_valid), 32'd1);
    check("lat3_result", bus_b.rsp_result, 32'h0000_00F0);
    check("lat3_status", 32'(bus_b.rsp_status), 32'h8);
    bus_b.rsp_ready = 1'b1;
    @(negedge clk);
    bus_b.rsp_ready = 1'b0;

    // saturation with 2-bit counters: five error completions in total
    for (int i = 0; i < 4; i++) begin
      accept_b(32'(i), 32'd0, 2'b00, 4'b1000);
      wait_rsp_b();
      check("sat_result", bus_b.rsp_result, 32'(i));
      bus_b.rsp_ready = 1'b1;
      @(negedge clk);
      bus_b.rsp_ready = 1'b0;
    end
    check("sat_done", 32'(bus_b.cnt_done), 32'd3);
    check("sat_err", 32'(bus_b.cnt_err), 32'd3);

    // asynchronous reset one cycle into WAIT aborts the command
    accept_b(32'h0000_00AA, 32'd1, 2'b10, 4'b0000);
    @(posedge clk);
    #2 rst_b = 1'b1;
    #1;
    check("abort_valid", 32'(bus_b.rsp_valid), 32'd0);
    check("abort_ready", 32'(bus_b.cmd_ready), 32'd0);
    check("abort_busy", 32'(bus_b.busy), 32'd0);
    check("abort_alu_a", bus_b.alu_arg_a, 32'd0);
    check("abort_alu_op", 32'(bus_b.alu_op), 32'd0);
    check("abort_result", bus_b.rsp_result, 32'd0);
    check("abort_cnt_done", 32'(bus_b.cnt_done), 32'd0);
    check("abort_cnt_err", 32'(bus_b.cnt_err), 32'd0);
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    check("abort_idle_ready", 32'(bus_b.cmd_ready), 32'd1);
    check("abort_idle_busy", 32'(bus_b.busy), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_b.rsp_valid) seen = 1'b1;
    end
    check("abort_no_rsp", 32'(seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
